// File: rtl/mem_stage_access.sv
// MEM stage of the 5-stage RISC-V core: runs loads/stores over a req/ack data-memory
// port, stalls the upstream pipeline while an access is in flight, and drives MEM/WB.
module mem_stage_access #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ALUout_i,
   input  logic [31:0] WD_i,
   input  logic [4:0]  RD_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic [31:0] ALUout_o,
   output logic [31:0] MemData_o,
   output logic [4:0]  RD_o,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic        misalign_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Last counter value of a BUSY stretch; reaching it without ack aborts the access.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] data_q, data_d;

   logic        access, aligned;
   logic        stall, bubble, latch_en;
   logic        set_misalign, set_timeout;

   logic [31:0] wb_alu_d, wb_data_d;
   logic [4:0]  wb_rd_d;
   logic        wb_rw_d, wb_m2r_d;

   assign access  = MemRead_i | MemWrite_i;
   assign aligned = (ALUout_i[1:0] == 2'b00);

   // The request is a pure function of the registered state, so reset kills it at once.
   assign mem_req_o = (state_q == BUSY);
   assign stall_o   = stall & rst_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         // NOTE: state elements use non-blocking assignments so every register samples
         // the pre-edge values regardless of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      stall        = 1'b0;
      bubble       = 1'b0;
      latch_en     = 1'b0;
      set_misalign = 1'b0;
      set_timeout  = 1'b0;
      wb_alu_d     = ALUout_i;
      wb_data_d    = '0;
      wb_rd_d      = RD_i;
      wb_rw_d      = RegWrite_i;
      wb_m2r_d     = MemtoReg_i;

      case (state_q)
         IDLE: begin
            if (access) begin
               if (!aligned) begin
                  set_misalign = 1'b1;
                  wb_rw_d      = 1'b0;
               end else begin
                  stall    = 1'b1;
                  bubble   = 1'b1;
                  latch_en = 1'b1;
                  cnt_d    = '0;
                  state_d  = BUSY;
               end
            end
         end

         BUSY: begin
            stall  = 1'b1;
            bubble = 1'b1;
            // Ack is checked first so a completion on the last allowed cycle is not lost.
            if (mem_ack_i) begin
               data_d  = mem_we_o ? 32'h0 : mem_rdata_i;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               data_d      = '0;
               set_timeout = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         DONE: begin
            wb_data_d = data_q;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (bubble) begin
         wb_alu_d  = '0;
         wb_data_d = '0;
         wb_rd_d   = '0;
         wb_rw_d   = 1'b0;
         wb_m2r_d  = 1'b0;
      end
   end

   // Memory-interface registers: captured once on entry to BUSY and held until the next access.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_we_o    <= 1'b0;
      end else if (latch_en) begin
         mem_addr_o  <= ALUout_i;
         mem_wdata_o <= WD_i;
         mem_we_o    <= MemWrite_i & ~MemRead_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ALUout_o   <= '0;
         MemData_o  <= '0;
         RD_o       <= '0;
         RegWrite_o <= 1'b0;
         MemtoReg_o <= 1'b0;
      end else begin
         ALUout_o   <= wb_alu_d;
         MemData_o  <= wb_data_d;
         RD_o       <= wb_rd_d;
         RegWrite_o <= wb_rw_d;
         MemtoReg_o <= wb_m2r_d;
      end
   end

   // Error flags stay set until the next reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         misalign_o <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         misalign_o <= misalign_o | set_misalign;
         timeout_o  <= timeout_o | set_timeout;
      end
   end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: ALU pass-through, load, store, misalign, timeout
// and mid-access reset, with a simple per-cycle memory responder.
module tb_mem_stage_access;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] ALUout_i;
   logic [31:0] WD_i;
   logic [4:0]  RD_i;
   logic        RegWrite_i;
   logic        MemtoReg_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        stall_o;
   logic [31:0] ALUout_o;
   logic [31:0] MemData_o;
   logic [4:0]  RD_o;
   logic        RegWrite_o;
   logic        MemtoReg_o;
   logic        misalign_o;
   logic        timeout_o;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_access #(.TIMEOUT_CYC(4)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .ALUout_i   (ALUout_i),
      .WD_i       (WD_i),
      .RD_i       (RD_i),
      .RegWrite_i (RegWrite_i),
      .MemtoReg_i (MemtoReg_i),
      .MemRead_i  (MemRead_i),
      .MemWrite_i (MemWrite_i),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_ack_i  (mem_ack_i),
      .mem_rdata_i(mem_rdata_i),
      .stall_o    (stall_o),
      .ALUout_o   (ALUout_o),
      .MemData_o  (MemData_o),
      .RD_o       (RD_o),
      .RegWrite_o (RegWrite_o),
      .MemtoReg_o (MemtoReg_o),
      .misalign_o (misalign_o),
      .timeout_o  (timeout_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                            input logic rw, input logic m2r, input logic mr, input logic mw);
      ALUout_i   = alu;
      WD_i       = wd;
      RD_i       = rd;
      RegWrite_i = rw;
      MemtoReg_i = m2r;
      MemRead_i  = mr;
      MemWrite_i = mw;
   endtask

   task automatic set_nop();
      set_instr(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Runs cycles while stall_o is high; acks on the (ack_k+1)-th request cycle (never if
   // ack_k < 0). Interface stability and the MEM/WB bubble are checked on every request cycle.
   task automatic run_access(input int ack_k, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic exp_we,
                             input logic [31:0] exp_wd, output int stall_cnt, output int req_cnt);
      logic ok;
      ok        = 1'b1;
      stall_cnt = 0;
      req_cnt   = 0;
      while (stall_o && stall_cnt < 40) begin
         stall_cnt++;
         if (mem_req_o) begin
            if (mem_addr_o !== exp_addr || mem_we_o !== exp_we || mem_wdata_o !== exp_wd ||
                RegWrite_o !== 1'b0)
               ok = 1'b0;
            mem_ack_i   = (req_cnt == ack_k);
            mem_rdata_i = (req_cnt == ack_k) ? rdata : 32'h0BAD_0BAD;
            req_cnt++;
         end
         @(posedge clk_i);
         #1;
         mem_ack_i   = 1'b0;
         mem_rdata_i = 32'h5555_AAAA;
         #1;
      end
      check("iface_stable", {31'b0, ok}, 32'd1);
   endtask

   initial begin
      int sc;
      int rc;
      rst_i       = 1'b0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      set_nop();
      #3;
      check("rst_req",   {31'b0, mem_req_o}, 32'd0);
      check("rst_stall", {31'b0, stall_o}, 32'd0);
      check("rst_wb",    {ALUout_o[15:0], MemData_o[7:0], 3'b0, RD_o}, 32'd0);
      check("rst_flags", {30'b0, misalign_o, timeout_o}, 32'd0);
      step();
      rst_i = 1'b1;
      #1;

      // Plain ALU instruction passes straight through.
      set_instr(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      check("alu_stall", {31'b0, stall_o}, 32'd0);
      check("alu_req",   {31'b0, mem_req_o}, 32'd0);
      step();
      check("alu_out",   ALUout_o, 32'h0000_1234);
      check("alu_rd",    {27'b0, RD_o}, 32'd5);
      check("alu_rw",    {31'b0, RegWrite_o}, 32'd1);
      check("alu_data",  MemData_o, 32'd0);

      // Load, ack three cycles after the request rises (lands on the last allowed cycle).
      set_instr(32'h0000_0100, 32'h1111_2222, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check("ld_stall0", {31'b0, stall_o}, 32'd1);
      check("ld_req0",   {31'b0, mem_req_o}, 32'd0);
      run_access(3, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 32'h1111_2222, sc, rc);
      check("ld_stall_cyc", sc, 32'd5);
      check("ld_req_cyc",   rc, 32'd4);
      check("ld_done_req",  {31'b0, mem_req_o}, 32'd0);
      check("ld_done_rw",   {31'b0, RegWrite_o}, 32'd0);
      check("ld_no_to",     {31'b0, timeout_o}, 32'd0);
      step();
      set_nop();
      #1;
      check("ld_data", MemData_o, 32'hDEAD_BEEF);
      check("ld_wb",   {26'b0, RegWrite_o, MemtoReg_o, 1'b0, RD_o[2:0]}, {26'b0, 1'b1, 1'b1, 1'b0, 3'd7});
      check("ld_alu",  ALUout_o, 32'h0000_0100);
      check("ld_req_after", {31'b0, mem_req_o}, 32'd0);

      // Store, acked in the first BUSY cycle; bus data on ack must not be captured.
      set_instr(32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      run_access(0, 32'h1234_5678, 32'h0000_0200, 1'b1, 32'hCAFE_F00D, sc, rc);
      check("st_stall_cyc", sc, 32'd2);
      check("st_req_cyc",   rc, 32'd1);
      check("st_done_req",  {31'b0, mem_req_o}, 32'd0);
      step();
      set_nop();
      #1;
      check("st_data",  MemData_o, 32'd0);
      check("st_alu",   ALUout_o, 32'h0000_0200);
      step();
      check("st_no_rereq", {31'b0, mem_req_o}, 32'd0);

      // Misaligned load, with a stray ack that IDLE must ignore.
      set_instr(32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
      mem_ack_i = 1'b1;
      #1;
      check("mis_stall", {31'b0, stall_o}, 32'd0);
      check("mis_req",   {31'b0, mem_req_o}, 32'd0);
      step();
      mem_ack_i = 1'b0;
      set_nop();
      #1;
      check("mis_flag", {31'b0, misalign_o}, 32'd1);
      check("mis_rw",   {31'b0, RegWrite_o}, 32'd0);
      check("mis_rd",   {27'b0, RD_o}, 32'd9);
      check("mis_alu",  ALUout_o, 32'h0000_0102);
      check("mis_req1", {31'b0, mem_req_o}, 32'd0);
      step();
      check("mis_held", {31'b0, misalign_o}, 32'd1);

      // Load that is never acked: aborted after four request cycles.
      set_instr(32'h0000_0300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      run_access(-1, 32'h0, 32'h0000_0300, 1'b0, 32'h0, sc, rc);
      check("to_stall_cyc", sc, 32'd5);
      check("to_req_cyc",   rc, 32'd4);
      check("to_flag",      {31'b0, timeout_o}, 32'd1);
      step();
      set_nop();
      #1;
      check("to_data", MemData_o, 32'd0);
      check("to_rw",   {31'b0, RegWrite_o}, 32'd1);
      step();
      check("to_held", {31'b0, timeout_o}, 32'd1);

      // Reset asserted in the second BUSY cycle.
      set_instr(32'h0000_0400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      step();
      step();
      check("rb_req_busy", {31'b0, mem_req_o}, 32'd1);
      rst_i = 1'b0;
      #1;
      check("rb_req",   {31'b0, mem_req_o}, 32'd0);
      check("rb_stall", {31'b0, stall_o}, 32'd0);
      check("rb_flags", {30'b0, misalign_o, timeout_o}, 32'd0);
      check("rb_rw",    {31'b0, RegWrite_o}, 32'd0);
      set_nop();
      step();
      rst_i = 1'b1;
      #1;
      check("rb_idle_stall", {31'b0, stall_o}, 32'd0);
      check("rb_idle_req",   {31'b0, mem_req_o}, 32'd0);

      // A fresh load after reset starts from IDLE.
      set_instr(32'h0000_0500, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      check("rb_ld_stall", {31'b0, stall_o}, 32'd1);
      step();
      check("rb_ld_req", {31'b0, mem_req_o}, 32'd1);
      run_access(0, 32'hA5A5_A5A5, 32'h0000_0500, 1'b0, 32'h0, sc, rc);
      check("rb_ld_stall_cyc", sc, 32'd1);
      step();
      set_nop();
      #1;
      check("rb_ld_data", MemData_o, 32'hA5A5_A5A5);
      check("rb_ld_flags", {30'b0, misalign_o, timeout_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage RISC-V core.
- Performs loads and stores against a variable-latency data memory using a req/ack handshake.
- Holds the upstream pipeline while an access is in progress.
- Drives the MEM/WB register: ALU result, load data, destination register and WB control, with bubbles inserted during stalls.

Parameters:
TIMEOUT_CYC, 255, maximum BUSY cycles without mem_ack_i before the access is aborted (1..65535)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
ALUout_i  input  32  EX/MEM ALU result; this is the memory address for loads and stores
WD_i  input  32  EX/MEM store data
RD_i  input  5  EX/MEM destination register
RegWrite_i  input  1  EX/MEM register-write enable
MemtoReg_i  input  1  EX/MEM WB mux select
MemRead_i  input  1  EX/MEM load
MemWrite_i  input  1  EX/MEM store
mem_req_o  output  1  memory request, held high until ack
mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o is high
mem_addr_o  output  32  word address, latched
mem_wdata_o  output  32  store data, latched
mem_ack_i  input  1  memory completion, sampled only while mem_req_o is high
mem_rdata_i  input  32  read data, valid with mem_ack_i
stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM (combinational)
ALUout_o  output  32  MEM/WB ALU result
MemData_o  output  32  MEM/WB load data
RD_o  output  5  MEM/WB destination register
RegWrite_o  output  1  MEM/WB register-write enable
MemtoReg_o  output  1  MEM/WB WB mux select
misalign_o  output  1  sticky: access attempted with ALUout_i[1:0] != 0
timeout_o  output  1  sticky: access aborted by timeout

Behaviour:
- Reset is asynchronous, active-low on rst_i. On reset:
  - every output is 0; state = IDLE; timeout counter = 0.
  - mem_req_o drops immediately, including mid-access. The memory must tolerate an abandoned request.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE, no access (MemRead_i = MemWrite_i = 0):
  - stall_o = 0.
  - MEM/WB loads ALUout_i, RD_i, RegWrite_i, MemtoReg_i; MemData_o is loaded with 0.
- IDLE, misaligned access (MemRead_i or MemWrite_i set, ALUout_i[1:0] != 0):
  - No request is issued; stall_o = 0; misalign_o is set.
  - MEM/WB loads the instruction with RegWrite_o forced to 0.
- IDLE, aligned access:
  - stall_o = 1 in the same cycle; MEM/WB loads a bubble (RegWrite_o = 0, MemtoReg_o = 0; RD_o, ALUout_o and MemData_o = 0).
  - Latched into the memory interface: mem_addr_o = ALUout_i, mem_wdata_o = WD_i, mem_we_o = MemWrite_i & ~MemRead_i. If both MemRead_i and MemWrite_i are set, the access is a read.
  - Next state is BUSY, with mem_req_o = 1 from the next cycle.
- BUSY:
  - mem_req_o = 1, with mem_addr_o, mem_we_o and mem_wdata_o held stable; stall_o = 1; MEM/WB loads a bubble every cycle.
  - On mem_ack_i = 1: capture mem_rdata_i (reads) or 0 (writes) into an internal data register; clear mem_req_o at the clock edge; go to DONE.
  - The counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYC: drop the request, set timeout_o, capture data = 0, go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and timeout_o is not set.
- DONE:
  - stall_o = 0; mem_req_o = 0.
  - MEM/WB loads ALUout_i, RD_i, RegWrite_i, MemtoReg_i and MemData_o = captured data.
  - Next state is IDLE; no new request is made for the still-visible instruction.
  - In the following cycle, IDLE evaluates the next instruction normally, so back-to-back memory operations each pay the full sequence.
- Latency: if ack arrives k cycles after mem_req_o rises (k = 0 means ack in the first BUSY cycle):
  - stall_o is high for k+2 cycles.
  - MEM/WB is loaded at the end of the DONE cycle.
- mem_ack_i is ignored in IDLE and DONE.
- misalign_o and timeout_o are sticky and are cleared only by reset.

Test Plan:
- ALU op: ALUout_i = 0x0000_1234, RD_i = 5, RegWrite_i = 1, no memory access -> one cycle later ALUout_o = 0x1234, RD_o = 5, RegWrite_o = 1; stall_o never rises; mem_req_o stays 0.
- Load to 0x100, memory acks 3 cycles after req with rdata 0xDEAD_BEEF:
  - stall_o is high for 5 cycles; mem_addr_o = 0x100 and mem_we_o = 0 throughout.
  - RegWrite_o stays 0 during the stall; after DONE, MemData_o = 0xDEADBEEF and MemtoReg_o = 1.
- Store WD_i = 0xCAFE_F00D to 0x200, ack in the first BUSY cycle (k = 0) -> mem_we_o = 1, mem_wdata_o = 0xCAFEF00D, stall_o high for 2 cycles, DONE in the 3rd cycle, no repeated request.
- Load to 0x102 -> no mem_req_o, stall_o = 0, misalign_o = 1 and held, RegWrite_o = 0 for that instruction.
- TIMEOUT_CYC = 4, ack never asserted -> mem_req_o high for 4 cycles, then drops; timeout_o = 1; MemData_o = 0.
- Assert rst_i = 0 in the 2nd BUSY cycle -> mem_req_o and stall_o drop immediately; after release, state is IDLE and flags are 0.
